rs_syndrome_engine: RTL
=======================

Name: rs_syndrome_engine

Overview:
- Parametrised syndrome generator for Reed-Solomon codes over GF(2^M). It is the first pipeline stage in front of the RS decoder's key-equation and Chien blocks.
- Accepts one parallel N-symbol codeword on a start strobe, evaluates r(x) at the 2T = N-K consecutive roots alpha^FCR .. alpha^(FCR+N-K-1) by serial Horner iteration (one symbol per enabled cycle), and presents registered syndromes with a done pulse and a nonzero-syndrome flag.
- The default configuration is RS(7,3) over GF(8).

Parameters:
- M, 3, symbol width in bits; field is GF(2^M).
- N, 7, codeword length in symbols; legal range 3 <= N <= 2^M-1.
- K, 3, message length in symbols; N-K must be even and >= 2.
- PRIM_POLY, 4'b1011, primitive polynomial including the x^M term (width M+1); default is x^3+x+1; alpha = 2.
- FCR, 1, exponent of the first consecutive root.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  clock enable for RUN; low freezes the computation
- start  in  1  single-cycle request; sampled only when busy=0
- codeword  in  N*M  received word; r_i at bits [(N-1-i)*M +: M], so r_0 sits in the MSB slice
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; syndromes and error_detected are valid from this cycle on
- syndromes  out  (N-K)*M  S_(FCR+j) at bits [j*M +: M], j = 0..N-K-1
- error_detected  out  1  OR of all syndrome bits, registered with the syndromes

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, symbol counter = 0, accumulators = 0, syndromes = 0, busy = 0, done = 0, error_detected = 0. Reset mid-RUN aborts the computation; no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 → latch codeword into the shift register, clear all N-K accumulators, set counter = N-1, go to RUN.
  - RUN: each clk edge with enable=1 processes r_counter (highest degree first, r_(N-1) first): acc_j <= gfmul(acc_j, alpha^(FCR+j)) XOR r_counter for every j in parallel. The counter then decrements.
  - RUN, enable=0: accumulators, counter and state hold.
  - RUN, edge that processes r_0: load the syndromes register from the final accumulator values, compute error_detected from them, go to DONE.
  - DONE: done=1 for exactly one cycle. start=1 in DONE is accepted (back-to-back operation) and goes straight to RUN. Otherwise go to IDLE. enable does not gate the DONE state.
- start is ignored while busy=1; the codeword input is don't-care after the capture edge.
- Latency: start captured at edge E0; done is high in the cycle after edge E0+N enabled edges. With enable held high, done asserts N+1 cycles after start is sampled.
- syndromes and error_detected hold their values until the next DONE; they do not change during RUN.
- GF arithmetic:
  - Addition is XOR.
  - Constant multiply by alpha^e: e repeated shift-left steps, each followed by a conditional XOR with PRIM_POLY[M-1:0] when the bit shifted out is 1. Exponents are taken mod (2^M-1).
  - All multipliers are combinational and elaborated from the parameters; no lookup ROMs.
- Zero symbol inputs are legal; an all-zero codeword yields all-zero syndromes and error_detected=0.

Test Plan:
- codeword=21'h000000, start for 1 cycle, enable=1 → done exactly 8 cycles after start is sampled; syndromes=0; error_detected=0; busy high for 7 cycles.
- r_0=1 only (codeword=21'h040000) → S1..S4 = 1,1,1,1; error_detected=1.
- r_1=1 only (21'h008000) → S1..S4 = 2,4,3,6 (syndromes = 12'b110_011_100_010).
- r_6=1 only (21'h000001) → S1..S4 = 5,7,6,3. Repeat with enable deasserted for 3 cycles mid-RUN → same syndromes, done delayed by exactly 3 cycles.
- start pulsed during RUN → ignored, result unchanged. start asserted during the DONE cycle with a new codeword → new RUN begins immediately; previous syndromes stay visible until the second done.
- reset_n pulsed low at RUN cycle 3 → all outputs 0 asynchronously, no done. A subsequent start with 21'h008000 yields 2,4,3,6.

Source files
------------

// File: rtl/rs_syndrome_engine.sv
`default_nettype none
// ============================================================================
//  Module   : rs_syndrome_engine
//  Purpose  : Reed-Solomon syndrome generator over GF(2^M). A full N-symbol
//             codeword is captured on start. Its polynomial r(x) is then
//             evaluated at alpha^FCR .. alpha^(FCR+N-K-1) by serial Horner
//             steps, one symbol per enabled clock. The result is presented as
//             registered syndromes together with a one-cycle done pulse.
//  Ports    : clk            - rising-edge clock
//             reset_n        - asynchronous active-low reset
//             enable         - advances the Horner iteration while busy
//             start          - capture request, honoured only when not busy
//             codeword       - r_i at [(N-1-i)*M +: M] (r_0 in the MSB slice)
//             busy           - computation in progress
//             done           - one-cycle pulse, results valid from here on
//             syndromes      - S_(FCR+j) at [j*M +: M]
//             error_detected - OR-reduction of all syndrome bits
//  Revision : 1.0 - initial release
// ============================================================================
module rs_syndrome_engine #(
    parameter int         M         = 3,
    parameter int         N         = 7,
    parameter int         K         = 3,
    parameter logic [M:0] PRIM_POLY = 4'b1011,
    parameter int         FCR       = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 start,
    input  logic [N*M-1:0]       codeword,
    output logic                 busy,
    output logic                 done,
    output logic [(N-K)*M-1:0]   syndromes,
    output logic                 error_detected
);

    localparam int c_NK    = N - K;
    localparam int c_ORDER = (1 << M) - 1;
    localparam int c_CW    = $clog2(N);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Multiply by alpha^e. The loop bound is a constant, and the exponent is
    // an elaboration-time constant at every call site. As a result, this
    // reduces to a small XOR network.
    function automatic logic [M-1:0] f_mul_alpha(input logic [M-1:0] a, input int e);
        logic [M-1:0] v;
        logic         msb;
        int           em;
        v  = a;
        em = e % c_ORDER;
        for (int s = 0; s < c_ORDER; s++) begin
            if (s < em) begin
                msb = v[M-1];
                v   = v << 1;
                if (msb) begin
                    v = v ^ PRIM_POLY[M-1:0];
                end
            end
        end
        return v;
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_CW-1:0]     r_cnt;
    logic [N*M-1:0]      r_shift;
    logic [c_NK*M-1:0]   r_acc;
    logic [c_NK*M-1:0]   w_acc_next;
    logic [c_NK*M-1:0]   r_syn;
    logic                r_err;
    logic                w_capture;
    logic                w_step;
    logic                w_last;

    // The lowest slice of the shift register always holds the next symbol.
    // r_(N-1) sits in the LSB slice of the captured word, so shifting right
    // feeds the symbols highest degree first.
    generate
        for (genvar j = 0; j < c_NK; j++) begin : g_root
            assign w_acc_next[j*M +: M] =
                f_mul_alpha(r_acc[j*M +: M], FCR + j) ^ r_shift[M-1:0];
        end
    endgenerate

    assign w_capture = start && (r_state != c_RUN);
    assign w_step    = (r_state == c_RUN) && enable;
    assign w_last    = (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_RUN;
            c_RUN:   if (enable && w_last) w_state_next = c_DONE;
            c_DONE:  w_state_next = start ? c_RUN : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_acc   <= '0;
            r_syn   <= '0;
            r_err   <= 1'b0;
        end else if (w_capture) begin
            r_cnt   <= c_CW'(N - 1);
            r_shift <= codeword;
            r_acc   <= '0;
        end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_shift <= r_shift >> M;
            r_cnt   <= r_cnt - c_CW'(1);
            // The edge that consumes r_0 completes the evaluation.
            if (w_last) begin
                r_syn <= w_acc_next;
                r_err <= |w_acc_next;
            end
        end
    end

    assign busy           = (r_state == c_RUN);
    assign done           = (r_state == c_DONE);
    assign syndromes      = r_syn;
    assign error_detected = r_err;

endmodule
`default_nettype wire
